dmem_bridge: RTL
================

Name: dmem_bridge

Overview:
- Sits between the single-cycle core datapath and the external data-memory bus.
- Converts the core's combinational load/store (ALU result address, register write data, memwrite/memread) into a req/ack bus transaction.
- Stalls the core until the transaction completes, then presents read data for the register-file result mux.
- Detects misaligned accesses, bus errors and ack timeouts, and halts the core with a sticky fault code.

Parameters:
- TIMEOUT_CYCLES, 255, maximum REQ cycles allowed without bus_ack before a timeout fault (legal range 1..65535).
- ADDR_W, 32, address width (byte address).
- DATA_W, 32, data word width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; the block is in reset while reset = 0.
- cpu_addr  input  ADDR_W  byte address from the datapath ALU output.
- cpu_wdata  input  DATA_W  store data from the datapath.
- cpu_memwrite  input  1  store request.
- cpu_memread  input  1  load request.
- cpu_rdata  output  DATA_W  load data to the datapath.
- stall  output  1  freezes the PC and register-file write while 1.
- fault  output  1  sticky fault flag.
- fault_code  output  2  0 none, 1 misaligned, 2 bus error, 3 timeout.
- bus_req  output  1  transaction request.
- bus_we  output  1  1 = write, 0 = read.
- bus_addr  output  ADDR_W  latched address.
- bus_wdata  output  DATA_W  latched write data.
- bus_ack  input  1  transaction complete, sampled only in REQ.
- bus_err  input  1  error qualifier, valid with bus_ack.
- bus_rdata  input  DATA_W  read data, valid with bus_ack.

Behaviour:
- States: IDLE, REQ, DONE, FAULT.
- Reset (reset = 0, asynchronous):
  - state goes to IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0.
  - cpu_rdata register=0, fault=0, fault_code=0, timeout counter=0.
  - Reset mid-transaction drops bus_req immediately, without waiting for a clock edge.
- access = cpu_memread | cpu_memwrite. Both set is treated as a write (bus_we=1).
- IDLE:
  - stall = access (combinational).
  - access with cpu_addr[1:0]==0: latch addr, wdata and we; go to REQ.
  - access with cpu_addr[1:0]!=0: go to FAULT with code 1; no bus transaction.
  - No access: stay in IDLE. bus_ack in IDLE is ignored.
- REQ:
  - bus_req=1, stall=1; latched bus_* values are held stable for the whole REQ.
  - Timeout counter clears on entry and counts REQ cycles 1, 2, ...
  - bus_ack=1 and bus_err=0: capture bus_rdata into cpu_rdata (reads only; writes leave cpu_rdata unchanged); go to DONE.
  - bus_ack=1 and bus_err=1: go to FAULT with code 2.
  - No ack on REQ cycle TIMEOUT_CYCLES: go to FAULT with code 3.
  - An ack on that same last cycle wins over the timeout.
- DONE:
  - stall=0 for exactly one cycle; the core commits and cpu_rdata is valid.
  - Always returns to IDLE without resampling access, so there is no double issue.
- FAULT:
  - stall=1, bus_req=0, fault=1, fault_code held.
  - Exit only by reset.
- Latency:
  - Zero-wait ack (ack on REQ cycle 1): 3 cycles total, with stall high for 2.
  - Each extra wait cycle adds 1.
- cpu_rdata is registered; it holds its last value outside DONE.

Decomposition:
- Package dmem_bridge_pkg holds:
  - state enum (IDLE, REQ, DONE, FAULT);
  - fault-code enum (FC_NONE=0, FC_MISALIGN=1, FC_BUSERR=2, FC_TIMEOUT=3).
- One sub-module, mem_timeout_ctr:
  - inputs: clear, enable;
  - output: expired when count reaches TIMEOUT_CYCLES;
  - counter width $clog2(TIMEOUT_CYCLES+1).

Test Plan:
- Load from 0x0000_0010; bus_ack on REQ cycle 3 with bus_rdata=0xDEAD_BEEF.
  - bus_req high 3 cycles, bus_we=0, bus_addr=0x10.
  - stall high 4 cycles, then DONE with cpu_rdata=0xDEAD_BEEF and stall=0.
  - IDLE on the next cycle.
- Store 0x1234_5678 to 0x0000_0020 with zero-wait ack.
  - bus_we=1, bus_wdata=0x1234_5678 for 1 cycle.
  - stall high 2 cycles; cpu_rdata unchanged.
- Load from 0x0000_0013.
  - fault=1, fault_code=1, bus_req never asserts.
  - stall stays 1 until reset=0; after reset all outputs are 0.
- TIMEOUT_CYCLES=4, no ack: fault_code=3 after the 4th REQ cycle.
- TIMEOUT_CYCLES=4, ack on REQ cycle 4: normal completion, no fault.
- bus_ack with bus_err=1: fault_code=2.
- reset pulsed low while in REQ.
  - bus_req drops within the same cycle (asynchronous).
  - Next access after release runs normally.
- bus_ack pulses while IDLE with no access: no state change; stall=0.

Source files
------------

// File: rtl/dmem_bridge_pkg.sv
// Shared types for the data-memory bridge: FSM state and sticky fault codes.
// No logic; imported by the bridge top and its timeout counter.
// Fault codes are visible to the core as a 2-bit status field.
package dmem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE     = 2'd0,
        FC_MISALIGN = 2'd1,
        FC_BUSERR   = 2'd2,
        FC_TIMEOUT  = 2'd3
    } fault_code_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts enabled cycles since the last clear and flags the TIMEOUT_CYCLES-th one.
// expired is combinational in the cycle being counted, so the caller can act on it that edge.
// No backpressure; clear has priority over enable.
module mem_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    // count_q holds the number of enabled cycles already finished, so the
    // current enabled cycle is number count_q + 1.
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && (count_q != CNT_W'(TIMEOUT_CYCLES))) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign expired = enable && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/dmem_bridge.sv
// Turns the core's single-cycle load/store into a req/ack bus transaction and stalls the core.
// Latency: 3 cycles for a zero-wait ack (stall high 2), +1 per bus wait cycle.
// Backpressure: stall holds the core until DONE; faults halt it until reset.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_memwrite,
    input  logic              cpu_memread,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              stall,
    output logic              fault,
    output logic [1:0]        fault_code,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic              bus_err,
    input  logic [DATA_W-1:0] bus_rdata
);

    state_t      state_q, state_d;
    fault_code_t fault_code_q, fault_code_d;
    logic        set_fault;
    logic        latch_req;
    logic        capture_rdata;
    logic        access;
    logic        expired;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              we_q;

    assign access = cpu_memread | cpu_memwrite;

    mem_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_q != REQ),
        .enable (state_q == REQ),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        stall         = 1'b0;
        latch_req     = 1'b0;
        capture_rdata = 1'b0;
        set_fault     = 1'b0;
        fault_code_d  = FC_NONE;
        case (state_q)
            IDLE: begin
                stall = access;
                if (access) begin
                    if (cpu_addr[1:0] == 2'b00) begin
                        latch_req = 1'b1;
                        state_d   = REQ;
                    end else begin
                        set_fault    = 1'b1;
                        fault_code_d = FC_MISALIGN;
                        state_d      = FAULT;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                // An ack on the final allowed cycle takes precedence over expiry.
                if (bus_ack) begin
                    if (bus_err) begin
                        set_fault    = 1'b1;
                        fault_code_d = FC_BUSERR;
                        state_d      = FAULT;
                    end else begin
                        capture_rdata = !we_q;
                        state_d       = DONE;
                    end
                end else if (expired) begin
                    set_fault    = 1'b1;
                    fault_code_d = FC_TIMEOUT;
                    state_d      = FAULT;
                end
            end
            DONE: begin
                // Unconditional return: the core's access is still asserted here.
                state_d = IDLE;
            end
            FAULT: begin
                stall = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            rdata_q      <= '0;
            fault_code_q <= FC_NONE;
        end else begin
            if (latch_req) begin
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
                we_q    <= cpu_memwrite;
            end
            if (capture_rdata) begin
                rdata_q <= bus_rdata;
            end
            if (set_fault) begin
                fault_code_q <= fault_code_d;
            end
        end
    end

    // bus_req decodes the state register so an async reset drops it at once.
    assign bus_req    = (state_q == REQ);
    assign bus_we     = we_q;
    assign bus_addr   = addr_q;
    assign bus_wdata  = wdata_q;
    assign cpu_rdata  = rdata_q;
    assign fault      = (state_q == FAULT);
    assign fault_code = fault_code_q;

endmodule
